mac_row_acc: RTL and testbench
==============================

Name: mac_row_acc

Overview:
Parametrised successor to the single-lane mac_wrapper datapath. A row of `col` MAC lanes that broadcasts one unsigned activation per beat against per-lane signed weights. Each lane accumulates a vector of programmable length and emits all lane psums together with a one-cycle valid pulse. It is the compute row for the next-generation systolic/PE array: a 2-stage pipeline that accepts back-to-back vectors and offers optional saturating accumulation.

Parameters:
bw, 4, activation and weight width (activation unsigned, weight two's-complement)
psum_bw, 16, per-lane psum/accumulator width (must be >= 2*bw+1)
col, 8, number of MAC lanes
cnt_bw, 8, width of vector-length field and beat counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
in_valid  input  1  beat qualifier for in_a/in_w
in_a  input  bw  unsigned activation, broadcast to all lanes
in_w  input  col*bw  signed weights, lane k at [k*bw +: bw]
acc_len  input  cnt_bw  beats per vector; sampled on first beat of each vector
sat_en  input  1  1 = saturating accumulate, 0 = wrap; sampled on first beat with acc_len
clear  input  1  synchronous abort of the vector in progress
out_valid  output  1  one-cycle pulse, out_psum holds completed vector
out_psum  output  col*psum_bw  signed lane psums, lane k at [k*psum_bw +: psum_bw]
busy  output  1  high while a vector is partially accepted (between its first and last beat)

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset values: out_valid=0, out_psum=0, busy=0, all accumulators/counters/pipeline valids=0.
- Multiply: a zero-extended to bw+1 signed × w signed gives a 2*bw-bit signed product, sign-extended to psum_bw. No overflow is possible at the product stage.
- Stage 1 (P): on an accepted beat, register the per-lane products, a p_valid bit, a p_first bit (first beat of vector) and a p_last bit (beat count reaches length).
- Stage 2 (A):
  - If p_valid and p_first: acc = product (load, no add).
  - Else if p_valid: acc = acc + product.
- Last-beat output: if p_valid and p_last, the final sums go to out_psum and out_valid pulses the next cycle. out_psum holds its value until the next pulse.
- Latency: out_valid asserts 2 cycles after the clock edge that accepts the last beat.
- Beat counting:
  - Counter cnt counts accepted beats of the current vector. A beat is first when cnt==0.
  - On the first beat, len_q is latched from acc_len, with acc_len==0 treated as 1.
  - A beat is last when cnt+1==len_q, or on the first beat when the effective length is 1. On the last beat, cnt returns to 0.
- Gaps: in_valid may drop mid-vector. Nothing advances, busy stays 1, and accumulators hold.
- Back-to-back: the first beat of the next vector may arrive the cycle after the last beat of the previous one. The p_first load guarantees no carry-over and no bubble, so the sustained rate is 1 beat/cycle.
- Changes mid-vector: changes to acc_len or sat_en after the first beat are ignored until the next vector.
- Saturation (sat_en=1): the sum is computed at psum_bw+1 bits, then clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1] per lane, per beat (sticky clamp). With sat_en=0, the sum wraps modulo 2^psum_bw.
- busy: 1 from the cycle after a non-last first beat until the cycle after the last beat. It is 0 for length-1 vectors.
- clear:
  - Zeroes cnt, busy, p_valid and the accumulators. Any in-flight vector is dropped and no out_valid is produced for it. out_psum is not modified.
  - A beat presented in the same cycle as clear is discarded.
  - A vector whose last beat is already in stage A still completes.
- reset: has priority over clear and in_valid. Reset mid-vector discards everything, and out_psum goes to 0.

Test Plan:
- Basic dot product, col=2, acc_len=3, a={1,2,3}, lane0 w={1,2,3}, lane1 w={-1,-1,-1} -> one out_valid pulse 2 cycles after the 3rd beat; lane0=14, lane1=-6; busy high for exactly 2 cycles.
- Extremes, acc_len=1, a=15, w=-8 on all lanes -> every lane = -120 (0xFF88 at psum_bw=16); acc_len=0 behaves identically.
- Saturation with psum_bw=8, acc_len=2, a=15: w=7 gives sat_en=1 -> 127, sat_en=0 -> -46; w=-8 gives sat_en=1 -> -128, sat_en=0 -> 16.
- Back-to-back plus gaps: vector A (len 2, a=1, w=1) immediately followed by vector B (len 2, a=2, w=3) with a 3-cycle in_valid gap between B's beats -> A=2, then B=12; no carry-over from A; exactly two out_valid pulses.
- clear after beat 2 of a len-4 vector, then a new len-1 vector (a=5, w=2) -> no pulse for the aborted vector; next pulse = 10; out_psum holds the previous value until then.
- reset asserted mid-vector (beat 2 of 3) -> all outputs 0 the next cycle, no out_valid; a subsequent len-2 vector (a=3, w=-2) -> -12.

Source files
------------

// File: rtl/mac_row_acc.sv
// Row of `col` MAC lanes: one unsigned activation broadcast against per-lane signed
// weights, accumulated over a programmable-length vector through a 2-stage pipeline.
module mac_row_acc #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int cnt_bw  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [bw-1:0]            in_a,
    input  logic [col*bw-1:0]        in_w,
    input  logic [cnt_bw-1:0]        acc_len,
    input  logic                     sat_en,
    input  logic                     clear,
    output logic                     out_valid,
    output logic [col*psum_bw-1:0]   out_psum,
    output logic                     busy
);
    localparam logic [cnt_bw-1:0]         one_c   = cnt_bw'(1);
    localparam logic signed [psum_bw-1:0] sat_max = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] sat_min = {1'b1, {(psum_bw-1){1'b0}}};

    logic [cnt_bw-1:0]         cnt_q, cnt_d, len_q, len_d, eff_len;
    logic                      sat_q, sat_d, busy_q, busy_d;
    logic                      accept, first, last;
    logic                      p_valid_q, p_valid_d, p_first_q, p_first_d;
    logic                      p_last_q, p_last_d, p_sat_q, p_sat_d;
    logic signed [psum_bw-1:0] prod_q [col];
    logic signed [psum_bw-1:0] prod_d [col];
    logic signed [psum_bw-1:0] acc_q  [col];
    logic signed [psum_bw-1:0] acc_d  [col];
    logic                      a_last_q, a_last_d, out_valid_q, out_valid_d;
    logic [col*psum_bw-1:0]    out_psum_q, out_psum_d;

    // Activation is zero-extended so the product is a plain signed multiply.
    function automatic logic signed [psum_bw-1:0] lane_mul(input logic [bw-1:0] a,
                                                           input logic signed [bw-1:0] w);
        logic signed [2*bw-1:0] p;
        p = (2*bw)'($signed({1'b0, a})) * (2*bw)'(w);
        lane_mul = psum_bw'(p);
    endfunction

    // One extra guard bit detects overflow; clamp only when saturation is enabled.
    function automatic logic signed [psum_bw-1:0] acc_add(input logic signed [psum_bw-1:0] a,
                                                          input logic signed [psum_bw-1:0] b,
                                                          input logic sat);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (sat && (s[psum_bw] != s[psum_bw-1])) begin
            acc_add = s[psum_bw] ? sat_min : sat_max;
        end else begin
            acc_add = s[psum_bw-1:0];
        end
    endfunction

    // Beat counting and stage P: length/saturation mode latched on the first beat.
    always_comb begin
        accept    = in_valid && !clear;
        first     = (cnt_q == '0);
        eff_len   = first ? ((acc_len == '0) ? one_c : acc_len) : len_q;
        last      = ((cnt_q + one_c) == eff_len);
        cnt_d     = cnt_q;
        len_d     = len_q;
        sat_d     = sat_q;
        busy_d    = busy_q;
        if (clear) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (in_valid) begin
            cnt_d  = last ? '0 : cnt_q + one_c;
            busy_d = !last;
            if (first) begin
                len_d = eff_len;
                sat_d = sat_en;
            end else begin
                len_d = len_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        p_valid_d = accept;
        p_first_d = first;
        p_last_d  = last;
        p_sat_d   = first ? sat_en : sat_q;
        for (int k = 0; k < col; k++) begin
            prod_d[k] = accept ? lane_mul(in_a, in_w[k*bw +: bw]) : prod_q[k];
        end
    end

    // Stage A and output register; a final sum already in acc_q survives clear.
    always_comb begin
        a_last_d = 1'b0;
        for (int k = 0; k < col; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (clear) begin
            for (int k = 0; k < col; k++) begin
                acc_d[k] = '0;
            end
        end else if (p_valid_q) begin
            for (int k = 0; k < col; k++) begin
                acc_d[k] = p_first_q ? prod_q[k] : acc_add(acc_q[k], prod_q[k], p_sat_q);
            end
            a_last_d = p_last_q;
        end else begin
            a_last_d = 1'b0;
        end
        out_valid_d = a_last_q;
        out_psum_d  = out_psum_q;
        if (a_last_q) begin
            for (int k = 0; k < col; k++) begin
                out_psum_d[k*psum_bw +: psum_bw] = acc_q[k];
            end
        end else begin
            out_psum_d = out_psum_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            len_q       <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_sat_q     <= 1'b0;
            a_last_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            for (int k = 0; k < col; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_sat_q     <= p_sat_d;
            a_last_q    <= a_last_d;
            out_valid_q <= out_valid_d;
            out_psum_q  <= out_psum_d;
            for (int k = 0; k < col; k++) begin
                prod_q[k] <= prod_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_psum  = out_psum_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_row_acc.sv
// Directed bench for mac_row_acc: a 2-lane/16-bit row plus a 2-lane/8-bit row for saturation.
module tb_mac_row_acc;
    logic        clk = 1'b0;
    logic        reset, in_valid, sat_en, clear;
    logic [3:0]  in_a;
    logic [7:0]  in_w;
    logic [7:0]  acc_len;
    logic        out_valid, busy, out_valid8, busy8;
    logic [31:0] out_psum;
    logic [15:0] out_psum8;

    int n_vec = 0;
    int n_err = 0;
    int busy_hi = 0;
    logic [31:0] pulses[$];

    mac_row_acc #(.bw(4), .psum_bw(16), .col(2), .cnt_bw(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_w(in_w),
        .acc_len(acc_len), .sat_en(sat_en), .clear(clear),
        .out_valid(out_valid), .out_psum(out_psum), .busy(busy));

    mac_row_acc #(.bw(4), .psum_bw(8), .col(2), .cnt_bw(8)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_w(in_w),
        .acc_len(acc_len), .sat_en(sat_en), .clear(clear),
        .out_valid(out_valid8), .out_psum(out_psum8), .busy(busy8));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_hi <= busy_hi + 1;
        if (out_valid) pulses.push_back(out_psum);
    end

    task automatic beat(input logic [3:0] a, input logic [3:0] w0, input logic [3:0] w1,
                        input logic [7:0] len, input logic sat);
        in_a = a; in_w = {w1, w0}; acc_len = len; sat_en = sat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_pulse(output int lat);
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; in_a = 4'd0; in_w = 8'd0;
        acc_len = 8'd0; sat_en = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_psum !== 32'd0) begin n_err++; $display("FAIL reset_psum got %h want 0", out_psum); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int lat, b0, p0;
        b0 = busy_hi; p0 = pulses.size();
        beat(4'd1, 4'd1, 4'hF, 8'd3, 1'b0);
        beat(4'd2, 4'd2, 4'hF, 8'd3, 1'b0);
        beat(4'd3, 4'd3, 4'hF, 8'd3, 1'b0);
        wait_pulse(lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", lat); end
        n_vec++; if (out_psum[15:0] !== 16'd14) begin n_err++; $display("FAIL basic_lane0 got %h want 000e", out_psum[15:0]); end
        n_vec++; if (out_psum[31:16] !== 16'hFFFA) begin n_err++; $display("FAIL basic_lane1 got %h want fffa", out_psum[31:16]); end
        idle(3);
        n_vec++; if (busy_hi - b0 != 2) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 2", busy_hi - b0); end
        n_vec++; if (pulses.size() - p0 != 1) begin n_err++; $display("FAIL basic_pulses got %0d want 1", pulses.size() - p0); end
    endtask

    task automatic test_extremes;
        int lat, b0;
        b0 = busy_hi;
        beat(4'd15, 4'h8, 4'h8, 8'd1, 1'b0);
        wait_pulse(lat);
        n_vec++; if (out_psum !== 32'hFF88FF88) begin n_err++; $display("FAIL ext_len1 got %h want ff88ff88", out_psum); end
        idle(2);
        beat(4'd15, 4'h8, 4'h8, 8'd0, 1'b0);
        wait_pulse(lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL ext_len0_latency got %0d want 2", lat); end
        n_vec++; if (out_psum !== 32'hFF88FF88) begin n_err++; $display("FAIL ext_len0 got %h want ff88ff88", out_psum); end
        n_vec++; if (busy_hi != b0) begin n_err++; $display("FAIL ext_busy got %0d cycles want 0", busy_hi - b0); end
    endtask

    task automatic test_saturation;
        int lat;
        logic [3:0]  wv  [4] = '{4'd7, 4'd7, 4'h8, 4'h8};
        logic        sv  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  exp [4] = '{8'h7F, 8'hD2, 8'h80, 8'h10};
        for (int i = 0; i < 4; i++) begin
            beat(4'd15, wv[i], wv[i], 8'd2, sv[i]);
            beat(4'd15, wv[i], wv[i], 8'd2, ~sv[i]);
            wait_pulse(lat);
            n_vec++; if (out_psum8 !== {exp[i], exp[i]}) begin n_err++;
                $display("FAIL sat_case%0d got %h want %h", i, out_psum8, {exp[i], exp[i]}); end
            idle(1);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses.size();
        beat(4'd1, 4'd1, 4'd1, 8'd2, 1'b0);
        beat(4'd1, 4'd1, 4'd1, 8'd2, 1'b0);
        beat(4'd2, 4'd3, 4'd3, 8'd2, 1'b0);
        idle(3);
        beat(4'd2, 4'd3, 4'd3, 8'd7, 1'b1);
        idle(5);
        n_vec++;
        if (pulses.size() - p0 != 2) begin
            n_err++; $display("FAIL b2b_pulses got %0d want 2", pulses.size() - p0);
        end else begin
            n_vec++; if (pulses[p0] !== 32'h00020002) begin n_err++; $display("FAIL b2b_vecA got %h want 00020002", pulses[p0]); end
            n_vec++; if (pulses[p0+1] !== 32'h000C000C) begin n_err++; $display("FAIL b2b_vecB got %h want 000c000c", pulses[p0+1]); end
        end
    endtask

    task automatic test_clear;
        int p0, lat;
        p0 = pulses.size();
        beat(4'd1, 4'd1, 4'd1, 8'd4, 1'b0);
        beat(4'd1, 4'd1, 4'd1, 8'd4, 1'b0);
        clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy got %b want 0", busy); end
        idle(6);
        n_vec++; if (pulses.size() != p0) begin n_err++; $display("FAIL clear_no_pulse got %0d want 0", pulses.size() - p0); end
        n_vec++; if (out_psum !== 32'h000C000C) begin n_err++; $display("FAIL clear_hold got %h want 000c000c", out_psum); end
        beat(4'd5, 4'd2, 4'd2, 8'd1, 1'b0);
        wait_pulse(lat);
        n_vec++; if (out_psum !== 32'h000A000A) begin n_err++; $display("FAIL clear_next got %h want 000a000a", out_psum); end
    endtask

    task automatic test_reset_mid;
        int p0, lat;
        idle(2);
        p0 = pulses.size();
        beat(4'd1, 4'd1, 4'd1, 8'd3, 1'b0);
        beat(4'd1, 4'd1, 4'd1, 8'd3, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_vec++; if ({out_valid, busy, out_psum} !== 34'd0) begin n_err++;
            $display("FAIL rstmid_outputs got v=%b b=%b p=%h want all 0", out_valid, busy, out_psum); end
        idle(4);
        n_vec++; if (pulses.size() != p0) begin n_err++; $display("FAIL rstmid_no_pulse got %0d want 0", pulses.size() - p0); end
        beat(4'd3, 4'hE, 4'hE, 8'd2, 1'b0);
        beat(4'd3, 4'hE, 4'hE, 8'd2, 1'b0);
        wait_pulse(lat);
        n_vec++; if (out_psum !== 32'hFFF4FFF4) begin n_err++; $display("FAIL rstmid_next got %h want fff4fff4", out_psum); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
